pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Generic, parametrised pipeline stage register for the simple pipeline.
- Carries a data payload plus a control bundle (e.g. MemtoReg, RegWrite, RegDst) from one phase to the next.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the stage sustains one beat per cycle under back-pressure with no combinational ready path.
- Adds synchronous flush and bubble-safe control zeroing.
- Intended to replace per-phase hand-written control registers.

Parameters:
- DATA_W, 32, payload width in bits.
- CTL_W, 5, control bundle width; forced to 0 whenever the output is a bubble.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous flush; drops all held beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat (registered)
- in_data  in  DATA_W  upstream payload
- in_ctl  in  CTL_W  upstream control bundle
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to next phase
- out_ctl  out  CTL_W  control bundle to next phase
- stall_cnt  out  STALL_CNT_W  back-pressure cycle count (optional feature only)

Behaviour:
- Reset and clocking:
  - Reset is rst_n, synchronous, active-low; clock is clk.
  - Reset values: out_valid=0, out_data=0, out_ctl=0, in_ready=0, internal skid valid=0, stall_cnt=0.
  - in_ready rises to 1 on the first clock edge after rst_n is sampled high.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready is a flop, equal to NOT(skid entry occupied) for the next cycle.
  - There is no combinational path from out_ready to in_ready.
- Storage: main register (drives the outputs) plus one skid register.
- States and transitions, evaluated every clock edge:
  - EMPTY (main empty, skid empty):
    - Input transfer → ONE; main loads the input.
  - ONE (main full, skid empty):
    - Input transfer with output transfer → stay ONE; main reloads from the input.
    - Input transfer without output transfer → FULL; skid loads the input.
    - Output transfer only → EMPTY.
  - FULL (main full, skid full, in_ready=0):
    - Output transfer → ONE; main loads from the skid; skid is freed.
- Latency and ordering:
  - Latency is 1 cycle from input transfer to out_valid when the stage is EMPTY.
  - Strict FIFO order; no beat is lost or duplicated.
- Bubble safety:
  - out_ctl is all-zero whenever out_valid=0.
  - out_data holds its last value when invalid; downstream must not use it.
- Flush:
  - Priority order: reset > flush > normal operation.
  - On a flush cycle the next state is EMPTY, out_valid=0, out_ctl=0, and in_ready=1.
  - A beat handshaken in the same cycle as flush is discarded.
  - A flush while EMPTY has no effect.
- Back-pressure: holding out_ready=0 indefinitely holds the main and skid contents unchanged. Each entry's data and ctl stay bit-stable.
- Mid-operation reset: all held beats are discarded; the next cycle is identical to the post-reset state.
- Throughput: 1 beat/cycle when out_ready is continuously high.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- When undefined:
  - stall_cnt is tied to 0.
  - No counter logic is synthesised.
  - The port remains present.

Test Plan:
- Reset then stream: after rst_n goes high, in_ready=1 one cycle later. Send in_data 1,2,3,4 with in_ctl=5'h1F back-to-back and out_ready=1. out_data is 1,2,3,4 on consecutive cycles, first beat 1 cycle after its input transfer.
- Back-pressure fill:
  - Send A=0xA, then B=0xB while out_ready=0. The stage is FULL and in_ready=0 on the cycle after B is accepted.
  - Hold out_ready=0 for 10 cycles: out_data stays 0xA.
  - Release out_ready: out_data is 0xA then 0xB, and in_ready returns to 1 one cycle after A leaves.
- Flush in FULL state: with the stage holding 0xA and 0xB, assert flush for 1 cycle together with in_valid carrying 0xC. Next cycle out_valid=0, out_ctl=0, in_ready=1, and 0xC never appears at the output.
- Bubble zeroing: a single beat with in_ctl=5'h1F is consumed. On the next cycle, with no new input, out_valid=0 and out_ctl=5'h00.
- Random valid/ready: 1000 beats with 50% random in_valid and out_ready. The output sequence equals the input sequence exactly, and in_ready is never 1 while the skid entry is occupied.
- With PIPE_SKID_STALL_CNT_EN defined:
  - Hold one valid beat with out_ready=0 for 7 cycles: stall_cnt=7.
  - With STALL_CNT_W=3, 9 stalled cycles: stall_cnt=7 (saturated).
  - A flush does not change stall_cnt.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional back-pressure counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CTL_W       = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTL_W-1:0]       in_ctl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTL_W-1:0]       out_ctl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   w_main_data_nxt;
    logic [CTL_W-1:0]    r_main_ctl;
    logic [CTL_W-1:0]    w_main_ctl_nxt;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DATA_W-1:0]   w_skid_data_nxt;
    logic [CTL_W-1:0]    r_skid_ctl;
    logic [CTL_W-1:0]    w_skid_ctl_nxt;
    logic                w_in_xfer;
    logic                w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Next-state and datapath selection; ctl is zeroed whenever the stage goes empty.
    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctl_nxt  = r_main_ctl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctl_nxt  = r_skid_ctl;

        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt     = ST_ONE;
                    w_main_data_nxt = in_data;
                    w_main_ctl_nxt  = in_ctl;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_data_nxt = in_data;
                    w_main_ctl_nxt  = in_ctl;
                end else if (w_in_xfer) begin
                    w_state_nxt     = ST_FULL;
                    w_skid_data_nxt = in_data;
                    w_skid_ctl_nxt  = in_ctl;
                end else if (w_out_xfer) begin
                    w_state_nxt     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt     = ST_ONE;
                    w_main_data_nxt = r_skid_data;
                    w_main_ctl_nxt  = r_skid_ctl;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase

        if (flush) begin
            w_state_nxt     = ST_EMPTY;
            w_main_data_nxt = r_main_data;
            w_skid_data_nxt = r_skid_data;
            w_skid_ctl_nxt  = r_skid_ctl;
        end

        if (w_state_nxt == ST_EMPTY) begin
            w_main_ctl_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_main_data <= '0;
            r_main_ctl  <= '0;
            r_skid_data <= '0;
            r_skid_ctl  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_main_data <= w_main_data_nxt;
            r_main_ctl  <= w_main_ctl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctl  <= w_skid_ctl_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign out_ctl   = r_main_ctl;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles a valid beat is held back; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
